// File: rtl/serial_word_receiver_5bit.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, stop bit.
// Presents each correctly framed word in parallel with a one-cycle valid pulse.
//
// state | meaning
// IDLE  | line idle, waiting for a 0 start bit
// DATA  | shifting in WIDTH data bits, LSB first
// STOP  | sampling the stop bit; 1 publishes the word, 0 flags a framing error
module serial_word_receiver_5bit #(
    parameter int WIDTH = 5
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             serialInput,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] notout,
    output logic             wordValid,
    output logic             framingError,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] word_next;
    logic             valid_next;
    logic             error_next;

    always_ff @(posedge clockpulse or negedge clear) begin
        if (!clear) begin
            state        <= IDLE;
            count        <= '0;
            shreg        <= '0;
            out          <= '0;
            notout       <= '1;
            wordValid    <= 1'b0;
            framingError <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            shreg        <= shreg_next;
            out          <= word_next;
            notout       <= ~word_next;
            wordValid    <= valid_next;
            framingError <= error_next;
            busy         <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        shreg_next = shreg;
        word_next  = out;
        valid_next = 1'b0;
        error_next = 1'b0;
        case (state)
            IDLE: begin
                if (!serialInput) begin
                    state_next = DATA;
                    count_next = '0;
                end
            end
            DATA: begin
                shreg_next = {serialInput, shreg[WIDTH-1:1]};
                count_next = count + CW'(1);
                if (count == CW'(WIDTH - 1)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // A 0 stop bit is reported, not reused as the next start bit.
                if (serialInput) begin
                    word_next  = shreg;
                    valid_next = 1'b1;
                end else begin
                    error_next = 1'b1;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_word_receiver_5bit.sv
// Table-driven bench for serial_word_receiver_5bit with hand-written
// sequences for async reset, idle line and a line stuck at 0.
module tb_serial_word_receiver_5bit;

    logic       clockpulse;
    logic       clear;
    logic       serialInput;
    logic [4:0] out;
    logic [4:0] notout;
    logic       wordValid;
    logic       framingError;
    logic       busy;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic       c;
        logic       s;
        logic [4:0] o;
        logic       wv;
        logic       fe;
        logic       bz;
    } vec_t;

    vec_t vecs[$];

    serial_word_receiver_5bit #(.WIDTH(5)) dut (
        .clockpulse  (clockpulse),
        .clear       (clear),
        .serialInput (serialInput),
        .out         (out),
        .notout      (notout),
        .wordValid   (wordValid),
        .framingError(framingError),
        .busy        (busy)
    );

    initial clockpulse = 1'b0;
    always #5 clockpulse = ~clockpulse;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic c, input logic s, input logic [4:0] o,
                                input logic wv, input logic fe, input logic bz);
        vec_t v;
        v.c = c; v.s = s; v.o = o; v.wv = wv; v.fe = fe; v.bz = bz;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] o, input logic wv,
                           input logic fe, input logic bz);
        chk({tag, " out"}, out, o);
        chk({tag, " notout"}, notout, ~o);
        chk({tag, " wordValid"}, {4'b0, wordValid}, {4'b0, wv});
        chk({tag, " framingError"}, {4'b0, framingError}, {4'b0, fe});
        chk({tag, " busy"}, {4'b0, busy}, {4'b0, bz});
    endtask

    task automatic step(input logic c, input logic s);
        clear = c;
        serialInput = s;
        @(posedge clockpulse);
        #1;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        clear = 1'b1;
        serialInput = 1'b1;

        // Async reset asserted mid-cycle, checked before the next edge.
        #7 clear = 1'b0;
        #1 chk_all("reset", 5'b00000, 1'b0, 1'b0, 1'b0);
        @(posedge clockpulse);
        #1;

        // Frame 11000 (LSB first 0,0,0,1,1), good stop.
        add(1, 0, 5'h00, 0, 0, 1);
        add(1, 0, 5'h00, 0, 0, 1);
        add(1, 0, 5'h00, 0, 0, 1);
        add(1, 0, 5'h00, 0, 0, 1);
        add(1, 1, 5'h00, 0, 0, 1);
        add(1, 1, 5'h00, 0, 0, 1);
        add(1, 1, 5'h18, 1, 0, 0);
        add(1, 1, 5'h18, 0, 0, 0);
        // Data 1,0,1,0,1 with stop 0: framing error, out keeps 11000.
        add(1, 0, 5'h18, 0, 0, 1);
        add(1, 1, 5'h18, 0, 0, 1);
        add(1, 0, 5'h18, 0, 0, 1);
        add(1, 1, 5'h18, 0, 0, 1);
        add(1, 0, 5'h18, 0, 0, 1);
        add(1, 1, 5'h18, 0, 0, 1);
        add(1, 0, 5'h18, 0, 1, 0);
        add(1, 1, 5'h18, 0, 0, 0);
        // Back-to-back 10101 then 01010, no idle between.
        add(1, 0, 5'h18, 0, 0, 1);
        add(1, 1, 5'h18, 0, 0, 1);
        add(1, 0, 5'h18, 0, 0, 1);
        add(1, 1, 5'h18, 0, 0, 1);
        add(1, 0, 5'h18, 0, 0, 1);
        add(1, 1, 5'h18, 0, 0, 1);
        add(1, 1, 5'h15, 1, 0, 0);
        add(1, 0, 5'h15, 0, 0, 1);
        add(1, 0, 5'h15, 0, 0, 1);
        add(1, 1, 5'h15, 0, 0, 1);
        add(1, 0, 5'h15, 0, 0, 1);
        add(1, 1, 5'h15, 0, 0, 1);
        add(1, 0, 5'h15, 0, 0, 1);
        add(1, 1, 5'h0A, 1, 0, 0);
        add(1, 1, 5'h0A, 0, 0, 0);
        // Reset after three data bits abandons the frame.
        add(1, 0, 5'h0A, 0, 0, 1);
        add(1, 1, 5'h0A, 0, 0, 1);
        add(1, 1, 5'h0A, 0, 0, 1);
        add(1, 1, 5'h0A, 0, 0, 1);
        add(0, 1, 5'h00, 0, 0, 0);
        add(1, 1, 5'h00, 0, 0, 0);
        add(1, 1, 5'h00, 0, 0, 0);
        // Clean frame 00001 after reset.
        add(1, 0, 5'h00, 0, 0, 1);
        add(1, 1, 5'h00, 0, 0, 1);
        add(1, 0, 5'h00, 0, 0, 1);
        add(1, 0, 5'h00, 0, 0, 1);
        add(1, 0, 5'h00, 0, 0, 1);
        add(1, 0, 5'h00, 0, 0, 1);
        add(1, 1, 5'h01, 1, 0, 0);
        add(1, 1, 5'h01, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].c, vecs[i].s);
            chk_all($sformatf("vec%0d", i), vecs[i].o, vecs[i].wv, vecs[i].fe, vecs[i].bz);
        end

        // Idle line at 1 for 20 cycles.
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1);
            chk_all($sformatf("idle%0d", k), 5'h01, 1'b0, 1'b0, 1'b0);
        end

        // Line stuck at 0: a zero frame ends in a framing error every 7 edges.
        for (int k = 0; k < 21; k++) begin
            step(1'b1, 1'b0);
            chk_all($sformatf("stuck0_%0d", k), 5'h01, 1'b0,
                    (k % 7 == 6) ? 1'b1 : 1'b0, (k % 7 == 6) ? 1'b0 : 1'b1);
        end

        // Mid-cycle reset while busy returns outputs immediately.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        #2 clear = 1'b0;
        #1 chk_all("midreset", 5'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk_all("post_midreset", 5'h00, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
